// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : 8N1 UART transmitter fed by a small byte FIFO from the MMIO path.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int LVL_W        = 4
) (
    input  logic             cpuclk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [LVL_W-1:0] fifo_level,
    output logic             tx_busy,
    output logic             tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0]  c_lvl_full  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [2:0]          r_bit;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic                r_tx;
    logic                w_tx_nxt;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [LVL_W-1:0]    w_level_nxt;
    logic                r_full;
    logic                r_empty;

    logic                w_pop;
    logic                w_push;
    logic                w_baud_done;

    assign w_baud_done = (r_baud == c_baud_last);
    // A pop frees a slot in the same cycle, so a write into a full FIFO is still taken.
    assign w_push      = wr_en && (!r_full || w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_bit_nxt   = r_bit + 3'd1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!r_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge cpuclk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= 3'd0;
            r_shift  <= 8'h00;
            r_tx     <= 1'b1;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_lvl_full);
            r_empty <= (w_level_nxt == '0);
        end
    end

    always_ff @(posedge cpuclk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign fifo_full  = r_full;
    assign fifo_empty = r_empty;
    assign fifo_level = r_level;
    assign tx_busy    = (r_state != S_IDLE);
    assign tx         = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          cpuclk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          tx_busy;
    logic          tx;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .LVL_W        (LW)
    ) u_dut (
        .cpuclk     (cpuclk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_level (fifo_level),
        .tx_busy    (tx_busy),
        .tx         (tx)
    );

    always #5 cpuclk = ~cpuclk;
    always @(posedge cpuclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent serial decoder: samples tx on falling edges, one sample per cycle.
    logic [7:0] mon_byte;
    int         mon_cnt   = -1;
    int         frame_err = 0;
    logic [7:0] rx_q[$];
    int         rx_start[$];

    always @(negedge cpuclk) begin
        int bi;
        if (rst) begin
            mon_cnt = -1;
        end else if (mon_cnt < 0) begin
            if (tx === 1'b0) begin
                mon_cnt = 1;
                rx_start.push_back(cyc);
            end
        end else begin
            bi = mon_cnt / CPB;
            if (bi >= 1 && bi <= 8) begin
                if (mon_cnt % CPB == 0) mon_byte[bi-1] = tx;
                else if (tx !== mon_byte[bi-1]) frame_err++;
            end else if (bi == 0 && tx !== 1'b0) begin
                frame_err++;
            end else if (bi == 9 && tx !== 1'b1) begin
                frame_err++;
            end
            mon_cnt++;
            if (mon_cnt == 10 * CPB) begin
                rx_q.push_back(mon_byte);
                mon_cnt = -1;
            end
        end
    end

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((tx_busy || !fifo_empty) && n < budget) begin
            @(negedge cpuclk);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        int         lows;
        logic [7:0] exp_b;

        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        repeat (3) @(negedge cpuclk);
        rst = 1'b0;
        check("rst_tx",    32'(tx),         32'd1);
        check("rst_busy",  32'(tx_busy),    32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full",  32'(fifo_full),  32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);

        repeat (20) @(negedge cpuclk);
        check("idle_tx",    32'(tx),          32'd1);
        check("idle_busy",  32'(tx_busy),     32'd0);
        check("idle_empty", 32'(fifo_empty),  32'd1);
        check("idle_level", 32'(fifo_level),  32'd0);
        check("idle_rx",    32'(rx_q.size()), 32'd0);

        // Single frame 0x55: latency and frame length
        k = cyc + 1;
        wr_en = 1'b1; wr_data = 8'h55;
        @(negedge cpuclk);
        wr_en = 1'b0;
        check("lat_empty", 32'(fifo_empty), 32'd0);
        check("lat_level", 32'(fifo_level), 32'd1);
        check("lat_tx_hi", 32'(tx),         32'd1);
        @(negedge cpuclk);
        check("start_tx",    32'(tx),         32'd0);
        check("start_busy",  32'(tx_busy),    32'd1);
        check("start_empty", 32'(fifo_empty), 32'd1);
        while (tx_busy && (cyc - k) < 100) @(negedge cpuclk);
        check("frame_len", 32'(cyc - k), 32'd41);
        check("f55_cnt",   32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("f55_byte", 32'(rx_q[0]), 32'h55);

        // Back-to-back frames 0xA3, 0x0F
        rx_q.delete(); rx_start.delete();
        wr_en = 1'b1; wr_data = 8'hA3;
        @(negedge cpuclk);
        wr_data = 8'h0F;
        @(negedge cpuclk);
        wr_en = 1'b0;
        wait_idle(300, "b2b_timeout");
        check("b2b_cnt", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() >= 2) begin
            check("b2b_byte0", 32'(rx_q[0]), 32'hA3);
            check("b2b_byte1", 32'(rx_q[1]), 32'h0F);
        end
        if (rx_start.size() >= 2) check("b2b_gap", 32'(rx_start[1] - rx_start[0]), 32'd40);

        // Fill to full, drop on overflow, then write on the STOP->START pop cycle
        rx_q.delete(); rx_start.delete();
        k = cyc + 1;
        for (int i = 1; i <= 10; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge cpuclk);
        end
        wr_en = 1'b0;
        check("full_level", 32'(fifo_level), 32'd8);
        check("full_flag",  32'(fifo_full),  32'd1);
        check("full_busy",  32'(tx_busy),    32'd1);
        while (cyc < k + 40) @(negedge cpuclk);
        check("prepop_level", 32'(fifo_level), 32'd8);
        wr_en = 1'b1; wr_data = 8'h0B;
        @(negedge cpuclk);
        wr_en = 1'b0;
        check("pushpop_level", 32'(fifo_level), 32'd8);
        check("pushpop_full",  32'(fifo_full),  32'd1);
        check("pushpop_tx",    32'(tx),         32'd0);
        wait_idle(800, "fill_timeout");
        check("fill_cnt", 32'(rx_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            exp_b = (i < 9) ? 8'(i + 1) : 8'h0B;
            check($sformatf("fill_byte%0d", i), 32'(rx_q[i]), 32'(exp_b));
        end
        check("frame_err", 32'(frame_err), 32'd0);

        // Reset during DATA bit 3 with three bytes queued
        rx_q.delete(); rx_start.delete();
        k = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h11 * (i + 1));
            @(negedge cpuclk);
        end
        wr_en = 1'b0;
        while (cyc < k + 17) @(negedge cpuclk);
        check("prerst_level", 32'(fifo_level), 32'd3);
        check("prerst_busy",  32'(tx_busy),    32'd1);
        rst = 1'b1;
        @(negedge cpuclk);
        rst = 1'b0;
        check("midrst_tx",    32'(tx),         32'd1);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_busy",  32'(tx_busy),    32'd0);
        check("midrst_empty", 32'(fifo_empty), 32'd1);
        check("midrst_full",  32'(fifo_full),  32'd0);
        lows = 0;
        repeat (100) begin
            @(negedge cpuclk);
            if (tx !== 1'b1) lows++;
        end
        check("postrst_quiet", 32'(lows),        32'd0);
        check("postrst_rx",    32'(rx_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter that serialises bytes written by the CPU MMIO path onto a single tx line.
- Output direction of the board UART link; complements the existing program-load receive path.
- Buffers bytes in a small FIFO and emits 8N1 frames at a fixed clocks-per-bit rate.
- Used by software for console and debug output.

Parameters:
CLKS_PER_BIT, 16, cpuclk cycles per UART bit; integer >= 2
FIFO_DEPTH, 8, FIFO entries; power of two, >= 2
LVL_W, 4, width of fifo_level; must equal log2(FIFO_DEPTH)+1

Ports:
cpuclk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
wr_en  input  1  push wr_data into the FIFO this cycle
wr_data  input  8  byte to transmit
fifo_full  output  1  FIFO holds FIFO_DEPTH entries
fifo_empty  output  1  FIFO holds 0 entries
fifo_level  output  LVL_W  current FIFO occupancy, range 0..FIFO_DEPTH
tx_busy  output  1  FSM not in IDLE
tx  output  1  serial line; idles high

Behaviour:
- Interface: one clock (cpuclk). Reset rst is synchronous and active-high.
- Reset values:
  - tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, fifo_level=0.
  - FSM=IDLE; bit counter, baud counter and FIFO pointers all 0.
- Reset mid-frame: at the reset edge the frame is abandoned, FIFO contents are discarded, and tx goes to 1.
- FIFO:
  - Write is accepted when wr_en=1 and (fifo_full=0 or a pop occurs in the same cycle).
  - A write while full with no pop is dropped silently; no state changes.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_full, fifo_empty and fifo_level are registered and reflect state after the edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. At an edge where fifo_empty=0: pop the head into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then shift right. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On completion:
    - if FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap);
    - otherwise go to IDLE.
- tx is a registered output; no glitches.
- Latency: a byte written at edge k into an empty FIFO with FSM in IDLE gives fifo_empty=0 after edge k. The pop occurs at edge k+1, and tx falls after edge k+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- A written byte can never be lost once accepted, except by reset.
- Baud counter range is 0..CLKS_PER_BIT-1; bit advance happens when the counter equals CLKS_PER_BIT-1.
- tx_busy=1 in START, DATA and STOP.

Test Plan:
- Reset, then idle 20 cycles -> tx=1, tx_busy=0, fifo_empty=1, fifo_level=0.
- CLKS_PER_BIT=4; write 0x55 at edge 10 -> tx=0 for cycles 11-14, then bits 1,0,1,0,1,0,1,0 each held 4 cycles, then tx=1 for 4 cycles; tx_busy deasserts after edge 51; total frame 40 cycles.
- Write 0xA3 then 0x0F on consecutive cycles -> two frames back-to-back with no idle gap; second start bit begins immediately after the first stop bit; serial bits 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- With tx busy, write 9 bytes 0x01..0x09 in 9 consecutive cycles with DEPTH=8 -> first byte popped, remaining 8 fill FIFO; fifo_full=1, fifo_level=8; the 10th write (0x0A) while full is dropped; exactly 0x01..0x09 appear on tx.
- With FIFO full, assert wr_en on the exact cycle of a STOP->START pop -> write accepted; fifo_level stays 8; byte later transmitted.
- Assert rst during DATA bit 3 with 3 bytes queued -> tx=1, fifo_level=0, tx_busy=0 after that edge; no further frames.
